// File: rtl/prog_freq_pkg.sv
// Shared constants and helpers for the programmable frequency generator.
package prog_freq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'd0;
    localparam mode_t MODE_PULSE  = 2'd1;
    localparam mode_t MODE_PWM    = 2'd2;
    localparam mode_t MODE_OFF    = 2'd3;

    // OFF is the one mode in which configuration may be swapped at any time.
    function automatic logic is_off(input mode_t m);
        return m == MODE_OFF;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Phase counter: counts 0..limit while enabled, wraps to 0 after limit.
module mod_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    assign count = count_q;
    assign tc    = en & (count_q == limit);

    // Next phase: clear wins, otherwise advance or wrap while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + W'(1);
        end
    end

    // Phase register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/prog_freq_gen.sv
// Programmable divider producing toggle, pulse or PWM waveforms from a
// double-buffered configuration that only takes effect on a period boundary.
module prog_freq_gen
    import prog_freq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         cfg_wr,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty,
    input  logic [1:0]   mode,
    output logic         out,
    output logic         tick,
    output logic         cfg_pending
);

    // Active configuration (drives the counter and waveform).
    logic [W-1:0] act_limit_q, act_limit_d;
    logic [W-1:0] act_duty_q,  act_duty_d;
    mode_t        act_mode_q,  act_mode_d;

    // Shadow configuration waiting for a safe point.
    logic [W-1:0] shd_limit_q, shd_limit_d;
    logic [W-1:0] shd_duty_q,  shd_duty_d;
    mode_t        shd_mode_q,  shd_mode_d;
    logic         pending_q,   pending_d;

    logic         out_q, out_d;

    logic [W-1:0] k;
    logic         tc;
    logic [W-1:0] wr_limit;
    logic         apply_ok;
    logic         apply;
    logic [W-1:0] new_limit;
    logic [W-1:0] new_duty;
    mode_t        new_mode;
    logic         mode_change;

    // Period 0 wraps to all-ones, which encodes P = 2^W.
    assign wr_limit = period - W'(1);

    // Safe to swap: end of a period, counter stalled, or output idle.
    assign apply_ok = tc | ~en | is_off(act_mode_q);
    assign apply    = (pending_q | cfg_wr) & apply_ok;

    // A write coinciding with the apply point bypasses the shadow.
    assign new_limit   = cfg_wr ? wr_limit : shd_limit_q;
    assign new_duty    = cfg_wr ? duty     : shd_duty_q;
    assign new_mode    = cfg_wr ? mode     : shd_mode_q;
    assign mode_change = apply & (new_mode != act_mode_q);

    mod_counter #(
        .W (W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr | apply),
        .en    (en),
        .limit (act_limit_q),
        .count (k),
        .tc    (tc)
    );

    assign tick        = tc;
    assign out         = out_q;
    assign cfg_pending = pending_q;

    // Shadow capture, pending flag and active-config swap.
    always_comb begin
        shd_limit_d = shd_limit_q;
        shd_duty_d  = shd_duty_q;
        shd_mode_d  = shd_mode_q;
        act_limit_d = act_limit_q;
        act_duty_d  = act_duty_q;
        act_mode_d  = act_mode_q;
        pending_d   = pending_q;
        if (cfg_wr) begin
            shd_limit_d = wr_limit;
            shd_duty_d  = duty;
            shd_mode_d  = mode;
        end
        if (apply) begin
            act_limit_d = new_limit;
            act_duty_d  = new_duty;
            act_mode_d  = new_mode;
            pending_d   = 1'b0;
        end else if (cfg_wr) begin
            pending_d = 1'b1;
        end
    end

    // Waveform next state; PWM compares the current phase against duty.
    always_comb begin
        out_d = out_q;
        if (clr | mode_change) begin
            out_d = 1'b0;
        end else if (en) begin
            unique case (act_mode_q)
                MODE_TOGGLE: out_d = tc ? ~out_q : out_q;
                MODE_PULSE:  out_d = tc;
                MODE_PWM:    out_d = (k < act_duty_q);
                MODE_OFF:    out_d = 1'b0;
            endcase
        end
    end

    // Configuration registers; reset leaves the block OFF with P = 2^W.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_limit_q <= '1;
            act_duty_q  <= '0;
            act_mode_q  <= MODE_OFF;
            shd_limit_q <= '1;
            shd_duty_q  <= '0;
            shd_mode_q  <= MODE_OFF;
            pending_q   <= 1'b0;
        end else begin
            act_limit_q <= act_limit_d;
            act_duty_q  <= act_duty_d;
            act_mode_q  <= act_mode_d;
            shd_limit_q <= shd_limit_d;
            shd_duty_q  <= shd_duty_d;
            shd_mode_q  <= shd_mode_d;
            pending_q   <= pending_d;
        end
    end

    // Registered waveform output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_prog_freq_gen.sv
// Directed self-checking bench for prog_freq_gen (W = 8).
module tb_prog_freq_gen;
    import prog_freq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         en = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] duty = '0;
    logic [1:0]   mode = MODE_OFF;
    logic         out;
    logic         tick;
    logic         cfg_pending;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prog_freq_gen #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .period      (period),
        .duty        (duty),
        .mode        (mode),
        .out         (out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; cfg_wr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wr_cfg(input int p, input int d, input logic [1:0] m);
        cfg_wr = 1'b1; period = p[W-1:0]; duty = d[W-1:0]; mode = m;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (out !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b exp 0", out); end
        n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
        n_cmp++; if (cfg_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending got %b exp 0", cfg_pending);
        end
    endtask

    task automatic test_toggle();
        logic et, eo;
        do_reset();
        wr_cfg(3, 0, MODE_TOGGLE);
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            et = (c % 3 == 2);
            eo = ((c / 3) % 2 == 1);
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL toggle_tick c=%0d got %b exp %b", c, tick, et);
            end
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL toggle_out c=%0d got %b exp %b", c, out, eo);
            end
            step();
        end
    endtask

    task automatic test_pwm();
        logic eo;
        // D = 3 of P = 10
        do_reset();
        wr_cfg(10, 3, MODE_PWM);
        en = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            eo = (c >= 1) && (((c - 1) % 10) < 3);
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL pwm3_out c=%0d got %b exp %b", c, out, eo);
            end
            step();
        end
        // D = 0: constant low
        do_reset();
        wr_cfg(10, 0, MODE_PWM);
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_cmp++; if (out !== 1'b0) begin
                n_fail++; $display("FAIL pwm0_out c=%0d got %b exp 0", c, out);
            end
            step();
        end
        // D = 12 >= P: constant high after the first registered cycle
        do_reset();
        wr_cfg(10, 12, MODE_PWM);
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            eo = (c >= 1);
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL pwm12_out c=%0d got %b exp %b", c, out, eo);
            end
            step();
        end
    endtask

    task automatic test_pulse();
        logic et, eo;
        do_reset();
        wr_cfg(0, 0, MODE_PULSE);
        en = 1'b1;
        for (int c = 0; c < 520; c++) begin
            #1;
            et = (c % 256 == 255);
            eo = (c > 0) && (c % 256 == 0);
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL pulse_tick c=%0d got %b exp %b", c, tick, et);
            end
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL pulse_out c=%0d got %b exp %b", c, out, eo);
            end
            step();
        end
    endtask

    task automatic test_reconfig();
        logic et, ep;
        do_reset();
        wr_cfg(10, 3, MODE_PWM);
        en = 1'b1;
        step();
        step();
        // cycle 2, k = 2: request P = 4
        cfg_wr = 1'b1; period = 8'd4; duty = 8'd3; mode = MODE_PWM;
        step();
        cfg_wr = 1'b0;
        for (int c = 3; c < 14; c++) begin
            #1;
            ep = (c <= 9);
            et = (c == 9) || (c == 13);
            n_cmp++; if (cfg_pending !== ep) begin
                n_fail++; $display("FAIL reconf_pending c=%0d got %b exp %b", c, cfg_pending, ep);
            end
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL reconf_tick c=%0d got %b exp %b", c, tick, et);
            end
            step();
        end
        // cycles 14 and 15: two writes, only P = 5 must survive
        cfg_wr = 1'b1; period = 8'd6;
        step();
        period = 8'd5;
        step();
        cfg_wr = 1'b0;
        for (int c = 16; c < 24; c++) begin
            #1;
            ep = (c <= 17);
            et = (c == 17) || (c == 22);
            n_cmp++; if (cfg_pending !== ep) begin
                n_fail++; $display("FAIL double_pending c=%0d got %b exp %b", c, cfg_pending, ep);
            end
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL double_tick c=%0d got %b exp %b", c, tick, et);
            end
            step();
        end
    endtask

    task automatic test_bypass();
        logic et;
        do_reset();
        wr_cfg(4, 0, MODE_TOGGLE);
        en = 1'b1;
        step(); step(); step();
        #1;
        n_cmp++; if (tick !== 1'b1) begin
            n_fail++; $display("FAIL bypass_pre_tick got %b exp 1", tick);
        end
        cfg_wr = 1'b1; period = 8'd2; mode = MODE_TOGGLE;
        step();
        cfg_wr = 1'b0;
        for (int c = 4; c < 8; c++) begin
            #1;
            et = (c % 2 == 1);
            n_cmp++; if (cfg_pending !== 1'b0) begin
                n_fail++; $display("FAIL bypass_pending c=%0d got %b exp 0", c, cfg_pending);
            end
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL bypass_tick c=%0d got %b exp %b", c, tick, et);
            end
            step();
        end
    endtask

    task automatic test_idle_write();
        logic et, eo;
        do_reset();
        wr_cfg(5, 0, MODE_PULSE);
        #1;
        n_cmp++; if (cfg_pending !== 1'b0) begin
            n_fail++; $display("FAIL idle_pending got %b exp 0", cfg_pending);
        end
        en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            et = (c == 4);
            eo = (c == 5);
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL idle_tick c=%0d got %b exp %b", c, tick, et);
            end
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL idle_out c=%0d got %b exp %b", c, out, eo);
            end
            step();
        end
    endtask

    task automatic test_clr();
        logic et, eo;
        do_reset();
        wr_cfg(10, 8, MODE_PWM);
        en = 1'b1;
        for (int c = 0; c < 5; c++) step();
        #1;
        n_cmp++; if (out !== 1'b1) begin
            n_fail++; $display("FAIL clr_pre_out got %b exp 1", out);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        // j counts cycles since clear; phase restarts at 0 with P = 10, D = 8 kept
        for (int j = 0; j < 10; j++) begin
            #1;
            et = (j == 9);
            eo = (j >= 1) && (j <= 8);
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL clr_tick j=%0d got %b exp %b", j, tick, et);
            end
            n_cmp++; if (out !== eo) begin
                n_fail++; $display("FAIL clr_out j=%0d got %b exp %b", j, out, eo);
            end
            step();
        end
    endtask

    task automatic test_en_hold();
        do_reset();
        wr_cfg(3, 0, MODE_TOGGLE);
        en = 1'b1;
        for (int c = 0; c < 5; c++) step();
        // cycle 5: k = 2, out = 1; stall here
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (tick !== 1'b0) begin
                n_fail++; $display("FAIL hold_tick c=%0d got %b exp 0", c, tick);
            end
            n_cmp++; if (out !== 1'b1) begin
                n_fail++; $display("FAIL hold_out c=%0d got %b exp 1", c, out);
            end
            step();
        end
        en = 1'b1;
        #1;
        n_cmp++; if (tick !== 1'b1) begin
            n_fail++; $display("FAIL resume_tick got %b exp 1", tick);
        end
        step();
        n_cmp++; if (out !== 1'b0) begin
            n_fail++; $display("FAIL resume_out got %b exp 0", out);
        end
    endtask

    task automatic test_rst_midrun();
        logic et;
        do_reset();
        wr_cfg(10, 5, MODE_PWM);
        en = 1'b1;
        step(); step(); step();
        cfg_wr = 1'b1; period = 8'd3; duty = 8'd1; mode = MODE_PWM;
        step();
        cfg_wr = 1'b0;
        #1;
        n_cmp++; if (cfg_pending !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_pending got %b exp 1", cfg_pending);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (cfg_pending !== 1'b0) begin
            n_fail++; $display("FAIL rst_pending got %b exp 0", cfg_pending);
        end
        // Reset config is OFF with P = 256: output stays low, tick at phase 255
        for (int c = 0; c < 260; c++) begin
            #1;
            et = (c == 255);
            n_cmp++; if (tick !== et) begin
                n_fail++; $display("FAIL rst_tick c=%0d got %b exp %b", c, tick, et);
            end
            n_cmp++; if (out !== 1'b0) begin
                n_fail++; $display("FAIL rst_out c=%0d got %b exp 0", c, out);
            end
            step();
        end
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_toggle();
        test_pwm();
        test_pulse();
        test_reconfig();
        test_bypass();
        test_idle_write();
        test_clr();
        test_en_hold();
        test_rst_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
